// File: rtl/instruction_fetch_unit.sv
// Instruction-fetch front end: PC sequencing, timed memory sampling, prefetch queue, redirect/exception flush.
// Optional macro IFU_ALIGN_CHECK_EN: misaligned redirect targets raise AlignFault and vector to EXC_VECTOR.
`timescale 1ns/1ps
module instruction_fetch_unit #(
    parameter int unsigned MEM_WAIT   = 1,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter logic [31:0] EXC_VECTOR = 32'hF000_0000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] StartPC,
    output logic [31:0] IMemAddress,
    input  logic [31:0] IMemData,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    input  logic        Exception,
    output logic        InstrValid,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    input  logic        InstrReady,
    output logic        AlignFault
);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned WW = 4;

    typedef enum logic [1:0] {BOOT, ACCESS, HOLD} state_e;

    state_e        state_q;
    logic [31:0]   pc_q;
    logic [WW-1:0] cnt_q;
    logic [31:0]   fifo_pc_q   [FIFO_DEPTH];
    logic [31:0]   fifo_data_q [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          valid_q;
    logic [31:0]   instr_q, instr_pc_q;
    logic          align_fault_q;

    logic          flush, pop, push_ok, sample, push, misaligned;
    logic [31:0]   target;
    logic [PW-1:0] rd_ptr_d, wr_ptr_d;
    logic [CW-1:0] count_d;
    logic [31:0]   head_pc_d, head_data_d;

    // Flush, handshake and next queue state; the head is precomputed so outputs stay registered
    always_comb begin
        flush   = (state_q != BOOT) && (Exception || Redirect);
        pop     = valid_q && InstrReady;
        push_ok = (count_q < CW'(FIFO_DEPTH)) || pop;
        sample  = ((state_q == ACCESS) && (cnt_q == WW'(MEM_WAIT))) || (state_q == HOLD);
        push    = sample && push_ok && !flush;
`ifdef IFU_ALIGN_CHECK_EN
        misaligned = Redirect && !Exception && (RedirectPC[1:0] != 2'b00);
        target     = (Exception || misaligned) ? (EXC_VECTOR & ~32'h3) : (RedirectPC & ~32'h3);
`else
        misaligned = 1'b0;
        target     = Exception ? (EXC_VECTOR & ~32'h3) : (RedirectPC & ~32'h3);
`endif
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
        head_pc_d   = '0;
        head_data_d = '0;
        if (count_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                head_pc_d   = pc_q;
                head_data_d = IMemData;
            end else begin
                head_pc_d   = fifo_pc_q[rd_ptr_d];
                head_data_d = fifo_data_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            cnt_q         <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            valid_q       <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            align_fault_q <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_pc_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            valid_q       <= (count_d != '0);
            instr_q       <= head_data_d;
            instr_pc_q    <= head_pc_d;
            align_fault_q <= flush && misaligned;
            if (push) begin
                fifo_pc_q[wr_ptr_q]   <= pc_q;
                fifo_data_q[wr_ptr_q] <= IMemData;
            end
            // Sequencer: BOOT loads StartPC once; a sample that cannot push parks in HOLD
            if (state_q == BOOT) begin
                pc_q    <= StartPC & ~32'h3;
                cnt_q   <= '0;
                state_q <= ACCESS;
            end else if (flush) begin
                pc_q    <= target;
                cnt_q   <= '0;
                state_q <= ACCESS;
            end else if (push) begin
                pc_q    <= pc_q + 32'd4;
                cnt_q   <= '0;
                state_q <= ACCESS;
            end else if (state_q == ACCESS) begin
                if (sample) state_q <= HOLD;
                else        cnt_q   <= cnt_q + WW'(1);
            end
        end
    end

    assign IMemAddress = pc_q;
    assign InstrValid  = valid_q;
    assign Instr       = instr_q;
    assign InstrPC     = instr_pc_q;
    assign AlignFault  = align_fault_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit (MEM_WAIT=1, FIFO_DEPTH=2) against a small instruction ROM.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;
    logic        CLK = 1'b0;
    logic        Reset;
    logic [31:0] StartPC;
    logic [31:0] IMemAddress;
    logic [31:0] IMemData;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        Exception;
    logic        InstrValid;
    logic [31:0] Instr;
    logic [31:0] InstrPC;
    logic        InstrReady;
    logic        AlignFault;

    int vectors = 0;
    int miscompares = 0;

    instruction_fetch_unit dut (
        .CLK(CLK), .Reset(Reset), .StartPC(StartPC), .IMemAddress(IMemAddress),
        .IMemData(IMemData), .Redirect(Redirect), .RedirectPC(RedirectPC),
        .Exception(Exception), .InstrValid(InstrValid), .Instr(Instr),
        .InstrPC(InstrPC), .InstrReady(InstrReady), .AlignFault(AlignFault)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0000_0000: rom = 32'h3408_0032;
            32'h0000_0004: rom = 32'hac08_0000;
            32'h0000_0008: rom = 32'h3408_0028;
            32'h0000_0060: rom = 32'h3404_0020;
            32'h0000_0190: rom = 32'hac09_0054;
            32'hF000_0000: rom = 32'h8c08_0000;
            default:       rom = a ^ 32'h5A5A_0000;
        endcase
    endfunction

    assign IMemData = rom(IMemAddress);

    task automatic do_boot(input logic [31:0] sp);
        @(negedge CLK);
        Reset = 1'b1; Redirect = 1'b0; Exception = 1'b0;
        repeat (2) @(negedge CLK);
        StartPC = sp;
        Reset = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        @(negedge CLK);
        vectors++; if (IMemAddress !== 32'h0) begin miscompares++; $display("FAIL rst_addr: got %h want %h", IMemAddress, 32'h0); end
        vectors++; if (InstrValid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", InstrValid); end
        vectors++; if (Instr !== 32'h0) begin miscompares++; $display("FAIL rst_instr: got %h want 0", Instr); end
        vectors++; if (InstrPC !== 32'h0) begin miscompares++; $display("FAIL rst_pc: got %h want 0", InstrPC); end
        vectors++; if (AlignFault !== 1'b0) begin miscompares++; $display("FAIL rst_af: got %b want 0", AlignFault); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc [3];
        logic [31:0] exp_in [3];
        exp_pc = '{32'h0, 32'h4, 32'h8};
        exp_in = '{32'h3408_0032, 32'hac08_0000, 32'h3408_0028};
        InstrReady = 1'b1;
        do_boot(32'h0);
        vectors++; if (IMemAddress !== 32'h0) begin miscompares++; $display("FAIL boot_addr: got %h want 0", IMemAddress); end
        vectors++; if (InstrValid !== 1'b0) begin miscompares++; $display("FAIL boot_valid_e1: got %b want 0", InstrValid); end
        @(negedge CLK);
        vectors++; if (InstrValid !== 1'b0) begin miscompares++; $display("FAIL boot_valid_e2: got %b want 0", InstrValid); end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            vectors++; if (InstrValid !== 1'b1) begin miscompares++; $display("FAIL stream_valid[%0d]: got %b want 1", i, InstrValid); end
            vectors++; if (InstrPC !== exp_pc[i]) begin miscompares++; $display("FAIL stream_pc[%0d]: got %h want %h", i, InstrPC, exp_pc[i]); end
            vectors++; if (Instr !== exp_in[i]) begin miscompares++; $display("FAIL stream_instr[%0d]: got %h want %h", i, Instr, exp_in[i]); end
            @(negedge CLK);
            vectors++; if (InstrValid !== 1'b0) begin miscompares++; $display("FAIL stream_gap[%0d]: got %b want 0", i, InstrValid); end
        end
    endtask

    task automatic test_backpressure();
        InstrReady = 1'b0;
        do_boot(32'h0);
        repeat (2) @(negedge CLK);
        vectors++; if (InstrPC !== 32'h0 || InstrValid !== 1'b1) begin miscompares++; $display("FAIL bp_first: got pc %h v %b want 0 1", InstrPC, InstrValid); end
        repeat (4) @(negedge CLK);
        vectors++; if (IMemAddress !== 32'h8) begin miscompares++; $display("FAIL bp_hold_addr: got %h want 8", IMemAddress); end
        repeat (3) @(negedge CLK);
        vectors++; if (IMemAddress !== 32'h8) begin miscompares++; $display("FAIL bp_hold_stable: got %h want 8", IMemAddress); end
        vectors++; if (InstrPC !== 32'h0 || Instr !== 32'h3408_0032) begin miscompares++; $display("FAIL bp_head0: got %h/%h want 0/34080032", InstrPC, Instr); end
        InstrReady = 1'b1;
        @(negedge CLK);
        vectors++; if (InstrPC !== 32'h4 || Instr !== 32'hac08_0000) begin miscompares++; $display("FAIL bp_head1: got %h/%h want 4/ac080000", InstrPC, Instr); end
        vectors++; if (IMemAddress !== 32'hC) begin miscompares++; $display("FAIL bp_resume_addr: got %h want c", IMemAddress); end
        @(negedge CLK);
        vectors++; if (InstrPC !== 32'h8 || Instr !== 32'h3408_0028 || InstrValid !== 1'b1) begin miscompares++; $display("FAIL bp_head2: got %h/%h v %b want 8/34080028 1", InstrPC, Instr, InstrValid); end
    endtask

    task automatic test_redirect();
        InstrReady = 1'b0;
        do_boot(32'h0);
        repeat (6) @(negedge CLK);
        vectors++; if (IMemAddress !== 32'h8) begin miscompares++; $display("FAIL rd_pre_full: got %h want 8", IMemAddress); end
        Redirect = 1'b1; RedirectPC = 32'h190;
        @(negedge CLK);
        Redirect = 1'b0; InstrReady = 1'b1;
        vectors++; if (InstrValid !== 1'b0) begin miscompares++; $display("FAIL rd_flush_valid: got %b want 0", InstrValid); end
        vectors++; if (IMemAddress !== 32'h190) begin miscompares++; $display("FAIL rd_addr: got %h want 190", IMemAddress); end
        @(negedge CLK);
        vectors++; if (InstrValid !== 1'b0) begin miscompares++; $display("FAIL rd_wait_valid: got %b want 0", InstrValid); end
        @(negedge CLK);
        vectors++; if (InstrValid !== 1'b1 || InstrPC !== 32'h190 || Instr !== 32'hac09_0054) begin miscompares++; $display("FAIL rd_first: got v %b %h/%h want 1 190/ac090054", InstrValid, InstrPC, Instr); end
        repeat (2) @(negedge CLK);
        vectors++; if (InstrValid !== 1'b1 || InstrPC !== 32'h194) begin miscompares++; $display("FAIL rd_second: got v %b pc %h want 1 194", InstrValid, InstrPC); end
    endtask

    task automatic test_exception_priority();
        InstrReady = 1'b1;
        do_boot(32'h0);
        repeat (2) @(negedge CLK);
        vectors++; if (InstrValid !== 1'b1) begin miscompares++; $display("FAIL ex_pre_valid: got %b want 1", InstrValid); end
        Exception = 1'b1; Redirect = 1'b1; RedirectPC = 32'h190;
        @(negedge CLK);
        Exception = 1'b0; Redirect = 1'b0;
        vectors++; if (InstrValid !== 1'b0) begin miscompares++; $display("FAIL ex_flush_valid: got %b want 0", InstrValid); end
        vectors++; if (IMemAddress !== 32'hF000_0000) begin miscompares++; $display("FAIL ex_addr: got %h want f0000000", IMemAddress); end
        repeat (2) @(negedge CLK);
        vectors++; if (InstrValid !== 1'b1 || InstrPC !== 32'hF000_0000 || Instr !== 32'h8c08_0000) begin miscompares++; $display("FAIL ex_first: got v %b %h/%h want 1 f0000000/8c080000", InstrValid, InstrPC, Instr); end
    endtask

    task automatic test_misaligned();
        logic [31:0] exp_pc;
        logic        exp_af;
`ifdef IFU_ALIGN_CHECK_EN
        exp_pc = 32'hF000_0000; exp_af = 1'b1;
`else
        exp_pc = 32'h190; exp_af = 1'b0;
`endif
        InstrReady = 1'b1;
        do_boot(32'h0);
        repeat (2) @(negedge CLK);
        Redirect = 1'b1; RedirectPC = 32'h192;
        @(negedge CLK);
        Redirect = 1'b0;
        vectors++; if (AlignFault !== exp_af) begin miscompares++; $display("FAIL mis_af: got %b want %b", AlignFault, exp_af); end
        vectors++; if (IMemAddress !== exp_pc) begin miscompares++; $display("FAIL mis_addr: got %h want %h", IMemAddress, exp_pc); end
        @(negedge CLK);
        vectors++; if (AlignFault !== 1'b0) begin miscompares++; $display("FAIL mis_af_pulse: got %b want 0", AlignFault); end
        @(negedge CLK);
        vectors++; if (InstrValid !== 1'b1 || InstrPC !== exp_pc || Instr !== rom(exp_pc)) begin miscompares++; $display("FAIL mis_first: got v %b %h/%h want 1 %h/%h", InstrValid, InstrPC, Instr, exp_pc, rom(exp_pc)); end
    endtask

    task automatic test_async_reset();
        InstrReady = 1'b0;
        do_boot(32'h100);
        repeat (3) @(negedge CLK);
        vectors++; if (InstrValid !== 1'b1 || IMemAddress !== 32'h104) begin miscompares++; $display("FAIL ar_pre: got v %b addr %h want 1 104", InstrValid, IMemAddress); end
        #1 Reset = 1'b1;
        #1;
        vectors++; if (IMemAddress !== 32'h0) begin miscompares++; $display("FAIL ar_addr: got %h want 0", IMemAddress); end
        vectors++; if (InstrValid !== 1'b0 || Instr !== 32'h0 || InstrPC !== 32'h0 || AlignFault !== 1'b0) begin miscompares++; $display("FAIL ar_outs: got v %b %h/%h af %b want 0 0/0 0", InstrValid, InstrPC, Instr, AlignFault); end
        InstrReady = 1'b1;
        do_boot(32'h60);
        repeat (2) @(negedge CLK);
        vectors++; if (InstrValid !== 1'b1 || InstrPC !== 32'h60 || Instr !== 32'h3404_0020) begin miscompares++; $display("FAIL ar_restart: got v %b %h/%h want 1 60/34040020", InstrValid, InstrPC, Instr); end
    endtask

    initial begin
        Reset = 1'b1; StartPC = 32'h0; Redirect = 1'b0; RedirectPC = 32'h0;
        Exception = 1'b0; InstrReady = 1'b1;
        @(negedge CLK);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_exception_priority();
        test_misaligned();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
